// File: rtl/pc_flow_ctrl.sv
// Program-counter flow controller: redirect arbitration, stall merge and
// JTAG halt/reset sequencing for the PC register and the IF/ID stage.
module pc_flow_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int RST_CYCLES   = 4,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_jump_i,
    input  logic [ADDR_W-1:0] ex_jump_addr_i,
    input  logic              ex_hold_i,
    input  logic              int_assert_i,
    input  logic [ADDR_W-1:0] int_addr_i,
    input  logic              clint_hold_i,
    input  logic              rib_hold_i,
    input  logic              jtag_halt_i,
    input  logic              jtag_reset_i,
    output logic              jump_flag_o,
    output logic [ADDR_W-1:0] jump_addr_o,
    output logic [2:0]        hold_flag_o,
    output logic              jtag_reset_flag_o,
    output logic              halted_o
);

    // state   | meaning
    // RUN     | normal flow, redirects and stalls pass through
    // RST     | stretched JTAG reset pulse, cnt counts it down
    // DRAIN   | front end held while the pipeline empties before halt
    // HALTED  | core parked for the debugger, everything held
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_RST    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam logic [2:0] HOLD_NONE = 3'd0;
    localparam logic [2:0] HOLD_PC   = 3'd1;
    localparam logic [2:0] HOLD_ID   = 3'd3;

    localparam logic [3:0] RST_LOAD   = 4'(RST_CYCLES - 1);
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       jtag_reset_q;
    logic       jtag_reset_flag_q;
    logic       halted_q;
    logic       rst_edge;

    assign rst_edge = jtag_reset_i & ~jtag_reset_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q           <= ST_RUN;
            cnt_q             <= 4'd0;
            jtag_reset_q      <= 1'b0;
            jtag_reset_flag_q <= 1'b0;
            halted_q          <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            jtag_reset_q      <= jtag_reset_i;
            jtag_reset_flag_q <= (state_d == ST_RST);
            halted_q          <= (state_d == ST_HALTED);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (rst_edge) begin
            state_d = ST_RST;
            cnt_d   = RST_LOAD;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (jtag_halt_i) begin
                        state_d = ST_DRAIN;
                        cnt_d   = DRAIN_LOAD;
                    end
                end
                ST_RST: begin
                    if (cnt_q == 4'd0) begin
                        if (jtag_halt_i) begin
                            state_d = ST_DRAIN;
                            cnt_d   = DRAIN_LOAD;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                ST_DRAIN: begin
                    // A dropped halt request aborts the drain before it completes.
                    if (!jtag_halt_i) begin
                        state_d = ST_RUN;
                        cnt_d   = 4'd0;
                    end else if (cnt_q == 4'd0) begin
                        state_d = ST_HALTED;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                ST_HALTED: begin
                    if (!jtag_halt_i) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    logic [2:0] run_hold;

    always_comb begin
        jump_flag_o = 1'b0;
        jump_addr_o = '0;
        hold_flag_o = HOLD_NONE;
        run_hold    = HOLD_NONE;
        if (rst) begin
            if (state_q == ST_RUN || state_q == ST_DRAIN) begin
                jump_flag_o = int_assert_i | ex_jump_i;
                if (int_assert_i) begin
                    jump_addr_o = int_addr_i;
                end else if (ex_jump_i) begin
                    jump_addr_o = ex_jump_addr_i;
                end
            end
            // A taken redirect flushes IF/ID, so it merges like a full stall.
            if (jump_flag_o || ex_hold_i || clint_hold_i) begin
                run_hold = HOLD_ID;
            end else if (rib_hold_i) begin
                run_hold = HOLD_PC;
            end
            case (state_q)
                ST_RUN:   hold_flag_o = run_hold;
                ST_DRAIN: hold_flag_o = (run_hold == HOLD_ID) ? HOLD_ID : HOLD_PC;
                default:  hold_flag_o = HOLD_ID;
            endcase
        end
    end

    assign jtag_reset_flag_o = jtag_reset_flag_q;
    assign halted_o          = halted_q;

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Bench for pc_flow_ctrl: directed test-plan sequences followed by random
// traffic, every output compared each cycle against a countdown model.
module tb_pc_flow_ctrl;

    localparam int ADDR_W       = 32;
    localparam int RST_CYCLES   = 4;
    localparam int DRAIN_CYCLES = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              ex_jump_i;
    logic [ADDR_W-1:0] ex_jump_addr_i;
    logic              ex_hold_i;
    logic              int_assert_i;
    logic [ADDR_W-1:0] int_addr_i;
    logic              clint_hold_i;
    logic              rib_hold_i;
    logic              jtag_halt_i;
    logic              jtag_reset_i;
    logic              jump_flag_o;
    logic [ADDR_W-1:0] jump_addr_o;
    logic [2:0]        hold_flag_o;
    logic              jtag_reset_flag_o;
    logic              halted_o;

    pc_flow_ctrl #(
        .ADDR_W      (ADDR_W),
        .RST_CYCLES  (RST_CYCLES),
        .DRAIN_CYCLES(DRAIN_CYCLES)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .ex_jump_i        (ex_jump_i),
        .ex_jump_addr_i   (ex_jump_addr_i),
        .ex_hold_i        (ex_hold_i),
        .int_assert_i     (int_assert_i),
        .int_addr_i       (int_addr_i),
        .clint_hold_i     (clint_hold_i),
        .rib_hold_i       (rib_hold_i),
        .jtag_halt_i      (jtag_halt_i),
        .jtag_reset_i     (jtag_reset_i),
        .jump_flag_o      (jump_flag_o),
        .jump_addr_o      (jump_addr_o),
        .hold_flag_o      (hold_flag_o),
        .jtag_reset_flag_o(jtag_reset_flag_o),
        .halted_o         (halted_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference: remaining pulse cycles, remaining drain cycles, halted flag.
    int m_pulse  = 0;
    int m_drain  = 0;
    bit m_halted = 1'b0;
    bit m_prev_jr = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        bit          blocked;
        bit          e_jump;
        logic [31:0] e_addr;
        int          e_hold;
        #1;
        blocked = (m_pulse > 0) || m_halted;
        e_jump  = rst && !blocked && (int_assert_i || ex_jump_i);
        e_addr  = !e_jump ? 32'h0 : (int_assert_i ? int_addr_i : ex_jump_addr_i);
        if (!rst) e_hold = 0;
        else if (blocked) e_hold = 3;
        else begin
            if (e_jump || ex_hold_i || clint_hold_i) e_hold = 3;
            else if (rib_hold_i) e_hold = 1;
            else e_hold = 0;
            if (m_drain > 0 && e_hold < 1) e_hold = 1;
        end
        check("jump_flag", 32'(jump_flag_o), 32'(e_jump));
        check("jump_addr", jump_addr_o, e_addr);
        check("hold_flag", 32'(hold_flag_o), 32'(e_hold));
        check("jtag_reset_flag", 32'(jtag_reset_flag_o), 32'(m_pulse > 0));
        check("halted", 32'(halted_o), 32'(m_halted));
        @(posedge clk);
        if (!rst) begin
            m_pulse = 0; m_drain = 0; m_halted = 1'b0; m_prev_jr = 1'b0;
        end else begin
            if (jtag_reset_i && !m_prev_jr) begin
                m_pulse = RST_CYCLES; m_drain = 0; m_halted = 1'b0;
            end else if (m_pulse > 0) begin
                m_pulse--;
                if (m_pulse == 0 && jtag_halt_i) m_drain = DRAIN_CYCLES;
            end else if (m_drain > 0) begin
                if (!jtag_halt_i) m_drain = 0;
                else begin
                    m_drain--;
                    if (m_drain == 0) m_halted = 1'b1;
                end
            end else if (m_halted) begin
                if (!jtag_halt_i) m_halted = 1'b0;
            end else if (jtag_halt_i) begin
                m_drain = DRAIN_CYCLES;
            end
            m_prev_jr = jtag_reset_i;
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; ex_jump_i = 0; ex_jump_addr_i = '0; ex_hold_i = 0;
        int_assert_i = 0; int_addr_i = '0; clint_hold_i = 0; rib_hold_i = 0;
        jtag_halt_i = 0; jtag_reset_i = 0;
        @(negedge clk);
        tick(); tick();
        rst = 1'b1;
        repeat (3) tick();
        // redirect collision, then execute alone
        ex_jump_i = 1; ex_jump_addr_i = 32'h100; int_assert_i = 1; int_addr_i = 32'h80;
        tick();
        int_assert_i = 0;
        tick();
        ex_jump_i = 0;
        // hold merge
        rib_hold_i = 1; tick();
        ex_hold_i = 1; tick();
        rib_hold_i = 0; ex_hold_i = 0; tick();
        // full halt, redirect ignored while halted, release
        jtag_halt_i = 1; repeat (6) tick();
        ex_jump_i = 1; tick(); ex_jump_i = 0;
        jtag_halt_i = 0; repeat (2) tick();
        // halt abort
        jtag_halt_i = 1; repeat (2) tick();
        jtag_halt_i = 0; repeat (3) tick();
        // JTAG reset while halted, held high without retrigger
        jtag_halt_i = 1; repeat (6) tick();
        jtag_reset_i = 1; repeat (12) tick();
        jtag_reset_i = 0; tick();
        // rst asserted mid-pulse
        jtag_reset_i = 1; repeat (2) tick();
        rst = 0; tick();
        rst = 1; jtag_reset_i = 0; jtag_halt_i = 0; repeat (3) tick();

        for (int i = 0; i < 3000; i++) begin
            ex_jump_i      = ($urandom_range(0, 3) == 0);
            ex_jump_addr_i = $urandom;
            int_assert_i   = ($urandom_range(0, 5) == 0);
            int_addr_i     = $urandom;
            ex_hold_i      = ($urandom_range(0, 4) == 0);
            clint_hold_i   = ($urandom_range(0, 7) == 0);
            rib_hold_i     = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 14) == 0) jtag_halt_i = ~jtag_halt_i;
            if ($urandom_range(0, 29) == 0) jtag_reset_i = ~jtag_reset_i;
            rst = ($urandom_range(0, 199) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
